// File: rtl/comp_vacc_readout_ctrl.sv
// Window/buffer sequencer for the double-buffered component vector accumulator:
// counts samples into windows, flips the write buffer and scans the closed one.
module comp_vacc_readout_ctrl #(
   parameter int unsigned SERIAL_ACC_LEN_BITS = 8,
   parameter int unsigned N_ANTS              = 8,
   parameter int unsigned READ_LATENCY        = 2
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        sync,
   input  logic                        en,
   input  logic                        out_rdy,
   output logic                        buf_sel,
   output logic [$clog2(N_ANTS)-1:0]   ant_a_sel,
   output logic [$clog2(N_ANTS)-1:0]   ant_b_sel,
   output logic                        rd_req,
   output logic                        out_vld,
   output logic                        last_bl,
   output logic                        overrun,
   output logic [15:0]                 win_cnt
);

   localparam int unsigned ANT_BITS = $clog2(N_ANTS);
   localparam int unsigned N_TAPS   = N_ANTS / 2 + 1;

   typedef enum logic {ST_IDLE, ST_ACC} acc_state_t;
   typedef enum logic {RD_IDLE, RD_RUN} rd_state_t;

   acc_state_t                     r_acc_state, w_acc_state_nxt;
   rd_state_t                      r_rd_state,  w_rd_state_nxt;
   logic [SERIAL_ACC_LEN_BITS-1:0] r_cnt,       w_cnt_nxt;
   logic                           r_buf_sel,   w_buf_sel_nxt;
   logic [15:0]                    r_win_cnt,   w_win_cnt_nxt;
   logic                           r_overrun,   w_overrun_nxt;
   logic [ANT_BITS-1:0]            r_ant_a,     w_ant_a_nxt;
   logic [ANT_BITS-1:0]            r_tap,       w_tap_nxt;
   logic [READ_LATENCY-1:0]        r_vld_pipe,  w_vld_pipe_nxt;
   logic [READ_LATENCY-1:0]        r_last_pipe, w_last_pipe_nxt;

   logic w_rd_req;
   logic w_final;
   logic w_win_end;

   // The buffer being read is always the complement of buf_sel while a scan
   // runs, so no separate read-buffer register is kept.
   always_comb begin
      w_acc_state_nxt = r_acc_state;
      w_rd_state_nxt  = r_rd_state;
      w_cnt_nxt       = r_cnt;
      w_buf_sel_nxt   = r_buf_sel;
      w_win_cnt_nxt   = r_win_cnt;
      w_overrun_nxt   = r_overrun;
      w_ant_a_nxt     = r_ant_a;
      w_tap_nxt       = r_tap;

      w_rd_req  = (r_rd_state == RD_RUN) && out_rdy;
      w_final   = (r_tap == ANT_BITS'(N_TAPS - 1)) && (r_ant_a == ANT_BITS'(N_ANTS - 1));
      w_win_end = (r_acc_state == ST_ACC) && en && (r_cnt == '1);

      if (w_rd_req) begin
         w_ant_a_nxt = r_ant_a + 1'b1;
         if (w_final) begin
            w_rd_state_nxt = RD_IDLE;
            w_ant_a_nxt    = '0;
            w_tap_nxt      = '0;
         end else if (r_ant_a == ANT_BITS'(N_ANTS - 1)) begin
            w_tap_nxt = r_tap + 1'b1;
         end
      end

      if (sync) begin
         w_acc_state_nxt = ST_ACC;
         w_cnt_nxt       = SERIAL_ACC_LEN_BITS'(en);
         w_buf_sel_nxt   = 1'b0;
         w_win_cnt_nxt   = '0;
         w_overrun_nxt   = 1'b0;
         w_rd_state_nxt  = RD_IDLE;
         w_ant_a_nxt     = '0;
         w_tap_nxt       = '0;
      end else if (r_acc_state == ST_ACC) begin
         if (en)
            w_cnt_nxt = r_cnt + 1'b1;
         if (w_win_end) begin
            w_buf_sel_nxt = ~r_buf_sel;
            w_win_cnt_nxt = r_win_cnt + 16'd1;
            // A scan finishing on this very cycle is complete, not overrun.
            if ((r_rd_state == RD_RUN) && !(w_rd_req && w_final))
               w_overrun_nxt = 1'b1;
            w_rd_state_nxt = RD_RUN;
            w_ant_a_nxt    = '0;
            w_tap_nxt      = '0;
         end
      end
   end

   always_comb begin
      w_vld_pipe_nxt     = '0;
      w_last_pipe_nxt    = '0;
      w_vld_pipe_nxt[0]  = w_rd_req;
      w_last_pipe_nxt[0] = w_rd_req && w_final;
      for (int unsigned i = 1; i < READ_LATENCY; i++) begin
         w_vld_pipe_nxt[i]  = r_vld_pipe[i-1];
         w_last_pipe_nxt[i] = r_last_pipe[i-1];
      end
      if (sync) begin
         w_vld_pipe_nxt  = '0;
         w_last_pipe_nxt = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_acc_state <= ST_IDLE;
         r_rd_state  <= RD_IDLE;
         r_cnt       <= '0;
         r_buf_sel   <= 1'b0;
         r_win_cnt   <= '0;
         r_overrun   <= 1'b0;
         r_ant_a     <= '0;
         r_tap       <= '0;
         r_vld_pipe  <= '0;
         r_last_pipe <= '0;
      end else begin
         r_acc_state <= w_acc_state_nxt;
         r_rd_state  <= w_rd_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_buf_sel   <= w_buf_sel_nxt;
         r_win_cnt   <= w_win_cnt_nxt;
         r_overrun   <= w_overrun_nxt;
         r_ant_a     <= w_ant_a_nxt;
         r_tap       <= w_tap_nxt;
         r_vld_pipe  <= w_vld_pipe_nxt;
         r_last_pipe <= w_last_pipe_nxt;
      end
   end

   assign buf_sel   = r_buf_sel;
   assign ant_a_sel = r_ant_a;
   assign ant_b_sel = r_ant_a - r_tap;
   assign rd_req    = w_rd_req;
   assign out_vld   = r_vld_pipe[READ_LATENCY-1];
   assign last_bl   = r_last_pipe[READ_LATENCY-1];
   assign overrun   = r_overrun;
   assign win_cnt   = r_win_cnt;

endmodule

// File: tb/tb_comp_vacc_readout_ctrl.sv
// Directed bench: dut A (16-sample windows) for scan/backpressure/sync cases,
// dut B (4-sample windows) for overrun and sync-during-readout.
module tb_comp_vacc_readout_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;
   logic a_sync, a_en, a_rdy, a_buf, a_req, a_vld, a_last, a_ovr;
   logic b_sync, b_en, b_rdy, b_buf, b_req, b_vld, b_last, b_ovr;
   logic [1:0]  a_ant_a, a_ant_b, b_ant_a, b_ant_b;
   logic [15:0] a_win, b_win;

   comp_vacc_readout_ctrl #(.SERIAL_ACC_LEN_BITS(4), .N_ANTS(4), .READ_LATENCY(2)) u_dut_a (
      .clk(clk), .rst(rst), .sync(a_sync), .en(a_en), .out_rdy(a_rdy),
      .buf_sel(a_buf), .ant_a_sel(a_ant_a), .ant_b_sel(a_ant_b), .rd_req(a_req),
      .out_vld(a_vld), .last_bl(a_last), .overrun(a_ovr), .win_cnt(a_win));

   comp_vacc_readout_ctrl #(.SERIAL_ACC_LEN_BITS(2), .N_ANTS(4), .READ_LATENCY(2)) u_dut_b (
      .clk(clk), .rst(rst), .sync(b_sync), .en(b_en), .out_rdy(b_rdy),
      .buf_sel(b_buf), .ant_a_sel(b_ant_a), .ant_b_sel(b_ant_b), .rd_req(b_req),
      .out_vld(b_vld), .last_bl(b_last), .overrun(b_ovr), .win_cnt(b_win));

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // {ant_a, ant_b} in baseline order for N_ANTS=4
   logic [3:0] exp_scan [12] = '{4'h0, 4'h5, 4'hA, 4'hF, 4'h3, 4'h4,
                                 4'h9, 4'hE, 4'h2, 4'h7, 4'h8, 4'hD};

   logic mon_sel, mon_on, mon_clr;
   logic m_req, m_vld, m_last, m_rdy;
   logic [1:0] m_a, m_b;
   assign m_req  = mon_sel ? b_req   : a_req;
   assign m_vld  = mon_sel ? b_vld   : a_vld;
   assign m_last = mon_sel ? b_last  : a_last;
   assign m_rdy  = mon_sel ? b_rdy   : a_rdy;
   assign m_a    = mon_sel ? b_ant_a : a_ant_a;
   assign m_b    = mon_sel ? b_ant_b : a_ant_b;

   int         cyc = 0;
   logic [3:0] q_addr [$];
   int         q_rcyc [$];
   int         q_vcyc [$];
   logic       q_last [$];
   int         n_last = 0;
   int         n_badreq = 0;

   always @(negedge clk) begin
      cyc++;
      if (mon_clr) begin
         q_addr.delete(); q_rcyc.delete(); q_vcyc.delete(); q_last.delete();
         n_last = 0; n_badreq = 0;
      end else if (mon_on) begin
         if (m_req) begin
            q_addr.push_back({m_a, m_b});
            q_rcyc.push_back(cyc);
            if (!m_rdy) n_badreq++;
         end
         if (m_vld) begin
            q_vcyc.push_back(cyc);
            q_last.push_back(m_last);
         end
         if (m_last) n_last++;
      end
   end

   task automatic check_scan(input string tag);
      chk($sformatf("%s_nreq", tag), q_addr.size(), 12);
      for (int i = 0; i < q_addr.size() && i < 12; i++)
         chk($sformatf("%s_addr%0d", tag, i), q_addr[i], exp_scan[i]);
      chk($sformatf("%s_nvld", tag), q_vcyc.size(), 12);
      for (int i = 0; i < q_vcyc.size() && i < q_rcyc.size(); i++) begin
         chk($sformatf("%s_lat%0d", tag, i), q_vcyc[i] - q_rcyc[i], 2);
         chk($sformatf("%s_last%0d", tag, i), q_last[i], (i == 11));
      end
      chk($sformatf("%s_nlast", tag), n_last, 1);
      chk($sformatf("%s_badreq", tag), n_badreq, 0);
   endtask

   logic seen;
   int   nv;

   initial begin
      rst = 1'b1;
      a_sync = 1'b0; a_en = 1'b0; a_rdy = 1'b1;
      b_sync = 1'b0; b_en = 1'b0; b_rdy = 1'b1;
      mon_sel = 1'b0; mon_on = 1'b0; mon_clr = 1'b0;
      repeat (3) step();
      chk("rst_a", {a_buf, a_req, a_vld, a_last, a_ovr, a_ant_a, a_ant_b, a_win}, 0);
      chk("rst_b", {b_buf, b_req, b_vld, b_last, b_ovr, b_ant_a, b_ant_b, b_win}, 0);

      // en without sync must not leave IDLE
      rst = 1'b0; a_en = 1'b1; b_en = 1'b1; seen = 1'b0;
      repeat (20) begin
         seen |= (|{a_buf, a_req, a_vld, a_last, a_ovr, a_ant_a, a_ant_b, a_win});
         seen |= (|{b_buf, b_req, b_vld, b_last, b_ovr, b_ant_a, b_ant_b, b_win});
         step();
      end
      chk("idle_quiet", seen, 0);

      // basic window and scan
      a_en = 1'b0; b_en = 1'b0; a_sync = 1'b1; step(); a_sync = 1'b0;
      mon_clr = 1'b1; step(); mon_clr = 1'b0; mon_on = 1'b1;
      a_en = 1'b1;
      for (int i = 0; i < 16; i++) begin
         if (i == 15) chk("a_buf_pre", a_buf, 0);
         step();
      end
      a_en = 1'b0;
      chk("a_buf_flip", a_buf, 1);
      chk("a_win1", a_win, 1);
      chk("a_first_req", {a_req, a_ant_a, a_ant_b}, 5'b1_00_00);
      repeat (30) step();
      check_scan("basic");
      chk("a_ovr_basic", a_ovr, 0);

      // backpressure 1,0,0,1
      mon_clr = 1'b1; step(); mon_clr = 1'b0;
      a_en = 1'b1;
      repeat (16) step();
      a_en = 1'b0;
      for (int i = 0; i < 48; i++) begin
         a_rdy = ((i % 4) == 0) || ((i % 4) == 3);
         step();
      end
      a_rdy = 1'b1;
      check_scan("bp");
      chk("a_buf_bp", a_buf, 0);
      chk("a_win_bp", a_win, 2);
      chk("a_ovr_bp", a_ovr, 0);

      // sync coincident with window end; sync-cycle en is sample 0
      a_en = 1'b1;
      repeat (15) step();
      a_sync = 1'b1; step(); a_sync = 1'b0;
      chk("co_buf", a_buf, 0);
      chk("co_win", a_win, 0);
      seen = 1'b0;
      for (int i = 0; i < 15; i++) begin
         seen |= a_req;
         if (i == 14) chk("co_buf_pre", a_buf, 0);
         step();
      end
      a_en = 1'b0;
      chk("co_no_req", seen, 0);
      chk("co_buf_flip", a_buf, 1);
      chk("co_win1", a_win, 1);

      // reset mid-scan
      repeat (3) step();
      rst = 1'b1; step();
      chk("rst_mid", {a_buf, a_req, a_vld, a_last, a_ovr, a_ant_a, a_ant_b, a_win}, 0);
      rst = 1'b0; a_en = 1'b1; seen = 1'b0;
      repeat (20) begin
         seen |= (|{a_buf, a_req, a_vld, a_last, a_ovr, a_win});
         step();
      end
      a_en = 1'b0;
      chk("rst_mid_quiet", seen, 0);

      // overrun with 4-sample windows
      mon_on = 1'b0; mon_sel = 1'b1;
      b_sync = 1'b1; step(); b_sync = 1'b0;
      mon_clr = 1'b1; step(); mon_clr = 1'b0; mon_on = 1'b1;
      b_en = 1'b1;
      for (int i = 0; i < 12; i++) begin
         if (i == 7) chk("b_ovr_pre", b_ovr, 0);
         step();
         if (i == 3) chk("b_win1", {b_buf, b_win}, {1'b1, 16'd1});
         if (i == 7) begin
            chk("b_ovr_set", b_ovr, 1);
            chk("b_restart", {b_req, b_ant_a, b_ant_b}, 5'b1_00_00);
            chk("b_buf_w2", b_buf, 0);
         end
      end
      b_en = 1'b0;
      chk("b_win3", {b_buf, b_win}, {1'b1, 16'd3});
      chk("b_ovr_hold", b_ovr, 1);
      chk("b_restart3", {b_req, b_ant_a, b_ant_b}, 5'b1_00_00);

      // sync after the 5th request of the restarted scan
      repeat (5) step();
      b_sync = 1'b1; step(); b_sync = 1'b0;
      chk("b_sync_state", {b_req, b_buf, b_ovr, b_win}, 0);
      nv = 0;
      repeat (5) begin
         nv += int'(b_vld);
         step();
      end
      chk("b_sync_vld_tail", (nv <= 1), 1);
      chk("b_no_last", n_last, 0);

      // next window yields a full scan
      mon_clr = 1'b1; step(); mon_clr = 1'b0;
      b_en = 1'b1;
      repeat (4) step();
      b_en = 1'b0;
      repeat (20) step();
      check_scan("b_full");
      chk("b_ovr_full", b_ovr, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/comp_vacc_readout_ctrl.md
Name: comp_vacc_readout_ctrl

Overview:
- Sequencer for the double-buffered component vector accumulator in the X-engine correction path.
- Counts valid samples into serial accumulation windows of 2^SERIAL_ACC_LEN_BITS and flips the write buffer at each window end.
- Scans the just-closed buffer in baseline order, issuing antenna-pair read addresses under downstream flow control.
- Flags an overrun when a readout cannot finish before the next buffer flip.

Parameters:
SERIAL_ACC_LEN_BITS, 8, log2 of samples per accumulation window
N_ANTS, 8, number of dual-pol antennas; power of two, >=2
READ_LATENCY, 2, accumulator BRAM read latency in clocks; >=1
ANT_BITS, log2(N_ANTS), derived localparam, not overridable
N_TAPS, N_ANTS/2+1, derived localparam, baseline offsets including auto

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
sync  in  1  alignment pulse; restarts window and buffer sequence
en  in  1  one valid sample entering the accumulator this cycle
out_rdy  in  1  downstream can accept corrections
buf_sel  out  1  buffer currently written by the accumulator
ant_a_sel  out  ANT_BITS  read address, antenna A
ant_b_sel  out  ANT_BITS  read address, antenna B
rd_req  out  1  read address valid this cycle
out_vld  out  1  rd_req delayed READ_LATENCY; correction data valid
last_bl  out  1  aligned with out_vld; final baseline of the readout
overrun  out  1  sticky; readout collided with a window end
win_cnt  out  16  completed windows since sync, wraps at 2^16

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; delay pipelines flushed.
- FSM states and transitions:
  - IDLE: ignore en; on sync go to ACC.
  - ACC: count en. On the en that makes the count SERIAL_ACC_LEN-1: the next cycle toggles buf_sel, clears the count, increments win_cnt, captures rd_buf = old buf_sel, and moves the readout sub-FSM to RUN.
- Readout sub-FSM:
  - RD_IDLE: rd_req=0.
  - RD_RUN: rd_req = out_rdy.
  - Address and order: addresses advance only on cycles with rd_req=1. Outer loop is tap t = 0..N_TAPS-1; inner loop is a = 0..N_ANTS-1. Outputs are ant_a_sel = a and ant_b_sel = (a - t) mod N_ANTS.
  - Completion: after request number N_ANTS*N_TAPS, return to RD_IDLE.
- Flow control: out_rdy is sampled combinationally into rd_req. Downstream must absorb up to READ_LATENCY outputs after it drops out_rdy, because there is no internal skid buffer.
- out_vld and last_bl: pure READ_LATENCY-stage shift of rd_req and of (rd_req & final address). They are independent of out_rdy after issue.
- Window end while in RD_RUN:
  - overrun <= 1.
  - The current scan is abandoned with no last_bl for it.
  - The scan restarts at t=0, a=0 on the newly closed buffer.
  - Requests already in the delay line still emerge.
- sync in ACC or IDLE:
  - Next cycle: count=0, buf_sel=0, win_cnt=0, overrun=0, readout to RD_IDLE; the in-flight delay line is flushed.
  - The en on the same cycle as sync is counted as sample 0 of the new window.
  - If sync and a window end coincide, sync wins: no flip, no readout.
- rst mid-operation: identical to the reset values; sync is required again to leave IDLE.
- Counters: the sample counter is SERIAL_ACC_LEN_BITS wide and wraps naturally. win_cnt wraps from 0xFFFF to 0 with no flag.

Test Plan:
- Reset-then-idle: assert rst 3 cycles, drive en=1 with no sync for 20 cycles -> all outputs stay 0, no rd_req.
- Basic window (SERIAL_ACC_LEN_BITS=4, N_ANTS=4, out_rdy=1): sync then 16 en -> buf_sel 0->1 on the cycle after the 16th en, win_cnt=1. Next 12 rd_req give (a,b) = (0,0)(1,1)(2,2)(3,3)(0,3)(1,0)(2,1)(3,2)(0,2)(1,3)(2,0)(3,1). out_vld follows 2 cycles later; last_bl is high only with (3,1); overrun stays 0.
- Backpressure: same config, out_rdy toggling 1,0,0,1 repeating -> rd_req only on out_rdy=1 cycles, address sequence unchanged, still 12 out_vld pulses, final last_bl.
- Overrun (SERIAL_ACC_LEN_BITS=2, N_ANTS=4, en=1 continuously): the 4-cycle window is shorter than the 12-cycle scan -> overrun=1 at the second window end; the scan restarts at (0,0) on buf_sel-complement; no last_bl ever asserts.
- Sync mid-readout: sync after the 5th rd_req of a scan -> next cycle rd_req=0, buf_sel=0, win_cnt=0, overrun cleared; out_vld asserts for at most READ_LATENCY-1 further cycles. The next window end produces a full 12-baseline scan.
- Coincident sync and window end: sync on the en that completes the window -> buf_sel stays 0, win_cnt=0, no rd_req; the counter reads 1 on the next cycle if en is held.
